riscv_base_alu_arb: RTL and testbench

RISCV_BASE_ALU_ARB -- requirements
Module: riscv_base_alu_arb

---
 rtl/riscv_base_alu_arb_pkg.sv | 29 ++
 rtl/riscv_base_alu.sv | 37 +++
 rtl/riscv_base_alu_arb.sv | 114 +++++++++++
 tb/tb_riscv_base_alu_arb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_base_alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: the ALU_* opcode
// encodings used by riscv_base_alu, and the arbiter-local constants.
// This is the single home of those constants; no other file keeps copies.
package riscv_base_alu_arb_pkg;

  // ALU opcode encodings
  localparam logic [3:0] ALU_NONE             = 4'b0000;
  localparam logic [3:0] ALU_SHIFTL           = 4'b0001;
  localparam logic [3:0] ALU_SHIFTR           = 4'b0010;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'b0011;
  localparam logic [3:0] ALU_ADD              = 4'b0100;
  localparam logic [3:0] ALU_SUB              = 4'b0110;
  localparam logic [3:0] ALU_AND              = 4'b0111;
  localparam logic [3:0] ALU_OR               = 4'b1000;
  localparam logic [3:0] ALU_XOR              = 4'b1001;
  localparam logic [3:0] ALU_LESS_THAN        = 4'b1010;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'b1011;

  // Arbiter constants
  localparam int ARB_REQ_N = 2;
  localparam int ARB_TAG_W = 4;

  // Requester index carried by the grant, the response id and last-grant
  typedef enum logic {
    GNT_REQ0 = 1'b0,
    GNT_REQ1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/riscv_base_alu.sv
// Combinational RISC-V base ALU. Unlisted opcodes pass operand A through.
module riscv_base_alu
  import riscv_base_alu_arb_pkg::*;
(
  input  logic [3:0]  alu_op_i,
  input  logic [31:0] alu_a_i,
  input  logic [31:0] alu_b_i,
  output logic [31:0] alu_p_o
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic [4:0]         shamt;

  assign a_s   = alu_a_i;
  assign b_s   = alu_b_i;
  assign shamt = alu_b_i[4:0];

  // Opcode decode to result
  always_comb begin
    alu_p_o = alu_a_i;
    case (alu_op_i)
      ALU_SHIFTL:           alu_p_o = alu_a_i << shamt;
      ALU_SHIFTR:           alu_p_o = alu_a_i >> shamt;
      ALU_SHIFTR_ARITH:     alu_p_o = a_s >>> shamt;
      ALU_ADD:              alu_p_o = alu_a_i + alu_b_i;
      ALU_SUB:              alu_p_o = alu_a_i - alu_b_i;
      ALU_AND:              alu_p_o = alu_a_i & alu_b_i;
      ALU_OR:               alu_p_o = alu_a_i | alu_b_i;
      ALU_XOR:              alu_p_o = alu_a_i ^ alu_b_i;
      ALU_LESS_THAN:        alu_p_o = {31'd0, (alu_a_i < alu_b_i)};
      ALU_LESS_THAN_SIGNED: alu_p_o = {31'd0, (a_s < b_s)};
      default:              alu_p_o = alu_a_i;
    endcase
  end

endmodule

// File: rtl/riscv_base_alu_arb.sv
// Two-requester arbiter in front of a single riscv_base_alu with a one-entry
// registered response slot. Define RISCV_BASE_ALU_ARB_RR_EN for round-robin
// arbitration; otherwise requester 0 has fixed priority.
module riscv_base_alu_arb
  import riscv_base_alu_arb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic [3:0]           req0_op_i,
  input  logic [31:0]          req0_a_i,
  input  logic [31:0]          req0_b_i,
  input  logic [ARB_TAG_W-1:0] req0_tag_i,
  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic [3:0]           req1_op_i,
  input  logic [31:0]          req1_a_i,
  input  logic [31:0]          req1_b_i,
  input  logic [ARB_TAG_W-1:0] req1_tag_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_result_o,
  output logic                 rsp_id_o,
  output logic [ARB_TAG_W-1:0] rsp_tag_o
);

  gnt_e                 gnt;
  gnt_e                 last_q, last_d;
  gnt_e                 id_q, id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          result_q, result_d;
  logic [ARB_TAG_W-1:0] tag_q, tag_d;
  logic                 slot_free;
  logic                 accept;
  logic [3:0]           op_mux;
  logic [31:0]          a_mux, b_mux;
  logic [ARB_TAG_W-1:0] tag_mux;
  logic [31:0]          alu_p;

  // Grant selection and ready generation; looks only at valids, rsp_ready_i and state
  always_comb begin
    slot_free = ~rsp_valid_q | rsp_ready_i;
    gnt       = GNT_REQ0;
    if (req0_valid_i && req1_valid_i) begin
`ifdef RISCV_BASE_ALU_ARB_RR_EN
      gnt = (last_q == GNT_REQ0) ? GNT_REQ1 : GNT_REQ0;
`else
      gnt = GNT_REQ0;
`endif
    end else if (req1_valid_i) begin
      gnt = GNT_REQ1;
    end
    req0_ready_o = ~rst_i & slot_free & req0_valid_i & (gnt == GNT_REQ0);
    req1_ready_o = ~rst_i & slot_free & req1_valid_i & (gnt == GNT_REQ1);
    accept       = req0_ready_o | req1_ready_o;
  end

  // 2:1 operation mux on the grant feeding the shared ALU
  always_comb begin
    op_mux  = (gnt == GNT_REQ1) ? req1_op_i  : req0_op_i;
    a_mux   = (gnt == GNT_REQ1) ? req1_a_i   : req0_a_i;
    b_mux   = (gnt == GNT_REQ1) ? req1_b_i   : req0_b_i;
    tag_mux = (gnt == GNT_REQ1) ? req1_tag_i : req0_tag_i;
  end

  riscv_base_alu u_alu (
    .alu_op_i (op_mux),
    .alu_a_i  (a_mux),
    .alu_b_i  (b_mux),
    .alu_p_o  (alu_p)
  );

  // Response slot next state: load on accept, drain when consumed, else hold
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    id_d        = id_q;
    tag_d       = tag_q;
    last_d      = last_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      result_d    = alu_p;
      id_d        = gnt;
      tag_d       = tag_mux;
      last_d      = gnt;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response and last-grant registers; reset discards any pending response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      id_q        <= GNT_REQ0;
      tag_q       <= '0;
      last_q      <= GNT_REQ1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      id_q        <= id_d;
      tag_q       <= tag_d;
      last_q      <= last_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign rsp_id_o     = id_q;
  assign rsp_tag_o    = tag_q;

endmodule

// File: tb/tb_riscv_base_alu_arb.sv
// Directed, table-driven bench for riscv_base_alu_arb. Follows the
// RISCV_BASE_ALU_ARB_RR_EN macro for the contention expectations.
module tb_riscv_base_alu_arb;
  import riscv_base_alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, r0, r1;
  logic [3:0]  op0, op1, tag0, tag1;
  logic [31:0] a0, b0, a1, b1;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  riscv_base_alu_arb dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_op_i(op0),
    .req0_a_i(a0), .req0_b_i(b0), .req0_tag_i(tag0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_op_i(op1),
    .req1_a_i(a1), .req1_b_i(b1), .req1_tag_i(tag1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_id_o(rsp_id), .rsp_tag_o(rsp_tag)
  );

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_g;
    vecs[0]  = '{1'b0, ALU_ADD,              32'd5,        32'd7,        4'd3,  32'd12};
    vecs[1]  = '{1'b0, ALU_SUB,              32'd5,        32'd7,        4'd1,  32'hFFFFFFFE};
    vecs[2]  = '{1'b1, ALU_AND,              32'h0000F0F0, 32'h00000FF0, 4'd7,  32'h000000F0};
    vecs[3]  = '{1'b1, ALU_OR,               32'h0000F0F0, 32'h00000FF0, 4'd8,  32'h0000FFF0};
    vecs[4]  = '{1'b0, ALU_XOR,              32'hFFFF0000, 32'h0F0F0F0F, 4'd9,  32'hF0F00F0F};
    vecs[5]  = '{1'b1, ALU_SHIFTL,           32'd1,        32'd31,       4'd2,  32'h80000000};
    vecs[6]  = '{1'b1, ALU_SHIFTL,           32'd1,        32'd33,       4'd4,  32'h00000002};
    vecs[7]  = '{1'b0, ALU_SHIFTR,           32'h80000000, 32'd4,        4'd5,  32'h08000000};
    vecs[8]  = '{1'b1, ALU_SHIFTR_ARITH,     32'h80000000, 32'd4,        4'd6,  32'hF8000000};
    vecs[9]  = '{1'b0, ALU_LESS_THAN_SIGNED, 32'hFFFFFFFF, 32'd1,        4'd10, 32'd1};
    vecs[10] = '{1'b0, ALU_LESS_THAN,        32'hFFFFFFFF, 32'd1,        4'd11, 32'd0};
    vecs[11] = '{1'b1, ALU_NONE,             32'h00001234, 32'd5,        4'd12, 32'h00001234};
    vecs[12] = '{1'b0, 4'b1111,              32'hDEADBEEF, 32'd1,        4'd15, 32'hDEADBEEF};

    rst = 1'b1; rsp_ready = 1'b1; idle();
    op0 = '0; a0 = '0; b0 = '0; tag0 = '0;
    op1 = '0; a1 = '0; b1 = '0; tag1 = '0;
    step();
    // Readies held low while reset is asserted, even with both valid
    v0 = 1'b1; v1 = 1'b1; op0 = ALU_ADD; a0 = 32'd1; b0 = 32'd1; tag0 = 4'd5;
    @(negedge clk);
    chk("rst_ready0", {31'd0, r0}, 32'd0);
    chk("rst_ready1", {31'd0, r1}, 32'd0);
    step();
    chk("rst_valid",  {31'd0, rsp_valid}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_id",     {31'd0, rsp_id}, 32'd0);
    chk("rst_tag",    {28'd0, rsp_tag}, 32'd0);
    rst = 1'b0; idle();
    step();

    // Single-requester vectors, one per cycle
    for (int i = 0; i < 13; i++) begin
      idle();
      if (vecs[i].id) begin
        v1 = 1'b1; op1 = vecs[i].op; a1 = vecs[i].a; b1 = vecs[i].b; tag1 = vecs[i].tag;
      end else begin
        v0 = 1'b1; op0 = vecs[i].op; a0 = vecs[i].a; b0 = vecs[i].b; tag0 = vecs[i].tag;
      end
      @(negedge clk);
      chk($sformatf("v%0d_ready0", i), {31'd0, r0}, {31'd0, ~vecs[i].id});
      chk($sformatf("v%0d_ready1", i), {31'd0, r1}, {31'd0, vecs[i].id});
      step();
      chk($sformatf("v%0d_valid", i),  {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), rsp_result, vecs[i].exp);
      chk($sformatf("v%0d_id", i),     {31'd0, rsp_id}, {31'd0, vecs[i].id});
      chk($sformatf("v%0d_tag", i),    {28'd0, rsp_tag}, {28'd0, vecs[i].tag});
    end

    // Drain without refill: valid drops, fields keep last values
    idle();
    step();
    chk("drain_valid",  {31'd0, rsp_valid}, 32'd0);
    chk("drain_result", rsp_result, 32'hDEADBEEF);
    chk("drain_tag",    {28'd0, rsp_tag}, 32'd15);

    // Contention for four cycles after reset
    do_reset();
    v0 = 1'b1; v1 = 1'b1; rsp_ready = 1'b1;
    op0 = ALU_ADD; a0 = 32'd100; b0 = 32'd1; tag0 = 4'd0;
    op1 = ALU_ADD; a1 = 32'd200; b1 = 32'd2; tag1 = 4'd1;
    for (int k = 0; k < 4; k++) begin
`ifdef RISCV_BASE_ALU_ARB_RR_EN
      exp_g = k[0];
`else
      exp_g = 1'b0;
`endif
      @(negedge clk);
      chk($sformatf("cont%0d_ready0", k), {31'd0, r0}, {31'd0, ~exp_g});
      chk($sformatf("cont%0d_ready1", k), {31'd0, r1}, {31'd0, exp_g});
      step();
      chk($sformatf("cont%0d_id", k), {31'd0, rsp_id}, {31'd0, exp_g});
      chk($sformatf("cont%0d_result", k), rsp_result, exp_g ? 32'd202 : 32'd101);
    end

    // Backpressure: held response, readies low, accept on rsp_ready rising
    do_reset();
    v1 = 1'b1; op1 = ALU_SHIFTR_ARITH; a1 = 32'h80000000; b1 = 32'd4; tag1 = 4'd9;
    rsp_ready = 1'b1;
    step();
    v1 = 1'b0;
    v0 = 1'b1; op0 = ALU_ADD; a0 = 32'd1; b0 = 32'd2; tag0 = 4'd4;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready0", k), {31'd0, r0}, 32'd0);
      chk($sformatf("bp%0d_ready1", k), {31'd0, r1}, 32'd0);
      chk($sformatf("bp%0d_valid", k),  {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_result", k), rsp_result, 32'hF8000000);
      chk($sformatf("bp%0d_id", k),     {31'd0, rsp_id}, 32'd1);
      chk($sformatf("bp%0d_tag", k),    {28'd0, rsp_tag}, 32'd9);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rise_ready0", {31'd0, r0}, 32'd1);
    step();
    chk("bp_next_result", rsp_result, 32'd3);
    chk("bp_next_id",     {31'd0, rsp_id}, 32'd0);
    chk("bp_next_tag",    {28'd0, rsp_tag}, 32'd4);

    // Reset while a response is pending discards it
    idle();
    v1 = 1'b1; op1 = ALU_XOR; a1 = 32'hAAAA5555; b1 = 32'h0; tag1 = 4'd13;
    step();
    idle(); rsp_ready = 1'b0;
    step();
    chk("pend_valid", {31'd0, rsp_valid}, 32'd1);
    chk("pend_id",    {31'd0, rsp_id}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("prst_valid",  {31'd0, rsp_valid}, 32'd0);
    chk("prst_result", rsp_result, 32'd0);
    chk("prst_id",     {31'd0, rsp_id}, 32'd0);
    chk("prst_tag",    {28'd0, rsp_tag}, 32'd0);
    v0 = 1'b1; v1 = 1'b1;
    @(negedge clk);
    chk("prst_cont_ready0", {31'd0, r0}, 32'd1);
    chk("prst_cont_ready1", {31'd0, r1}, 32'd0);
    step();
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
